// File: rtl/button_debouncer.sv
// Debounces active-low pushbuttons: two-flop synchroniser per pin, then a per-channel
// FSM producing a clean level and single-cycle press / release / long-press pulses.
module button_debouncer #(
   parameter int N_BUTTONS         = 3,
   parameter int DEBOUNCE_CYCLES   = 1000000,
   parameter int LONG_PRESS_CYCLES = 50000000
) (
   input  logic                   input_clk,
   input  logic                   reset,
   input  logic [N_BUTTONS-1:0]   buttons_n,
   output logic [N_BUTTONS-1:0]   pressed,
   output logic [N_BUTTONS-1:0]   press_pulse,
   output logic [N_BUTTONS-1:0]   release_pulse,
   output logic [N_BUTTONS-1:0]   long_press,
   output logic [2*N_BUTTONS-1:0] dbg_state
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam int HW = $clog2(LONG_PRESS_CYCLES) + 1;
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);
   localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS_CYCLES - 1);
   localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_PRESS_CYCLES);

   typedef enum logic [1:0] {
      ST_RELEASED     = 2'd0,
      ST_PRESS_WAIT   = 2'd1,
      ST_HELD         = 2'd2,
      ST_RELEASE_WAIT = 2'd3
   } state_t;

   // Synchroniser holds raw pin polarity, so "released" is all ones.
   logic [N_BUTTONS-1:0] sync_q1, sync_q2;
   logic [N_BUTTONS-1:0] s;

   always_ff @(posedge input_clk) begin
      if (reset) begin
         sync_q1 <= '1;
         sync_q2 <= '1;
      end else begin
         sync_q1 <= buttons_n;
         sync_q2 <= sync_q1;
      end
   end

   assign s = ~sync_q2;

   for (genvar i = 0; i < N_BUTTONS; i++) begin : g_ch
      state_t        state_q, state_d;
      logic [CW-1:0] cnt_q, cnt_d;
      logic [HW-1:0] hold_q, hold_d;
      logic          fired_q, fired_d;
      logic          pressed_q, pressed_d;
      logic          press_q, press_d;
      logic          release_q, release_d;
      logic          long_q, long_d;

      always_ff @(posedge input_clk) begin
         if (reset) begin
            state_q   <= ST_RELEASED;
            cnt_q     <= '0;
            hold_q    <= '0;
            fired_q   <= 1'b0;
            pressed_q <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
         end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hold_q    <= hold_d;
            fired_q   <= fired_d;
            pressed_q <= pressed_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
         end
      end

      always_comb begin
         state_d = state_q;
         cnt_d   = cnt_q;
         hold_d  = hold_q;
         fired_d = fired_q;
         case (state_q)
            ST_RELEASED: begin
               if (s[i]) begin
                  state_d = ST_PRESS_WAIT;
                  cnt_d   = CNT_ONE;
               end else begin
                  cnt_d = '0;
               end
            end
            ST_PRESS_WAIT: begin
               if (!s[i]) begin
                  state_d = ST_RELEASED;
                  cnt_d   = '0;
               end else if (cnt_q == CNT_LAST) begin
                  state_d = ST_HELD;
                  hold_d  = '0;
                  fired_d = 1'b0;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            ST_HELD: begin
               if (!s[i]) begin
                  state_d = ST_RELEASE_WAIT;
                  cnt_d   = CNT_ONE;
               end else begin
                  if (hold_q != HOLD_MAX) hold_d = hold_q + HW'(1);
                  if (hold_q == HOLD_LAST && !fired_q) fired_d = 1'b1;
               end
            end
            ST_RELEASE_WAIT: begin
               // A bounce back to pressed resumes HELD with hold frozen, not cleared.
               if (s[i]) begin
                  state_d = ST_HELD;
               end else if (cnt_q == CNT_LAST) begin
                  state_d = ST_RELEASED;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            default: state_d = ST_RELEASED;
         endcase
      end

      always_comb begin
         pressed_d = pressed_q;
         press_d   = 1'b0;
         release_d = 1'b0;
         long_d    = 1'b0;
         case (state_q)
            ST_PRESS_WAIT: begin
               if (s[i] && cnt_q == CNT_LAST) begin
                  pressed_d = 1'b1;
                  press_d   = 1'b1;
               end
            end
            ST_HELD: begin
               if (s[i] && hold_q == HOLD_LAST && !fired_q) long_d = 1'b1;
            end
            ST_RELEASE_WAIT: begin
               if (!s[i] && cnt_q == CNT_LAST) begin
                  pressed_d = 1'b0;
                  release_d = 1'b1;
               end
            end
            default: ;
         endcase
      end

      assign pressed[i]         = pressed_q;
      assign press_pulse[i]     = press_q;
      assign release_pulse[i]   = release_q;
      assign long_press[i]      = long_q;
      assign dbg_state[2*i +: 2] = state_q;
   end

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer (3 channels, debounce 4, long press 10).
// Stimulus pushes time-stamped expected events; a negedge monitor pops and compares them.
module tb_button_debouncer;

   localparam int N  = 3;
   localparam int EW = 32 + 4 * N;

   logic         input_clk;
   logic         reset;
   logic [N-1:0] buttons_n;
   logic [N-1:0] pressed, press_pulse, release_pulse, long_press;
   logic [2*N-1:0] dbg_state;

   logic [EW-1:0] exp_q[$];
   int            n_checks;
   int            n_fails;
   int            cyc;
   logic          mon_en;

   button_debouncer #(
      .N_BUTTONS        (N),
      .DEBOUNCE_CYCLES  (4),
      .LONG_PRESS_CYCLES(10)
   ) dut (
      .input_clk    (input_clk),
      .reset        (reset),
      .buttons_n    (buttons_n),
      .pressed      (pressed),
      .press_pulse  (press_pulse),
      .release_pulse(release_pulse),
      .long_press   (long_press),
      .dbg_state    (dbg_state)
   );

   // Clock / reset / edge counter
   initial input_clk = 1'b0;
   always #5 input_clk = ~input_clk;

   initial cyc = 0;
   always @(posedge input_clk) cyc <= cyc + 1;

   // Driver helpers: all drives happen 1 time unit after a rising edge.
   task automatic wait_cyc(input int n);
      repeat (n) @(posedge input_clk);
      #1;
   endtask

   task automatic push_exp(input int off, input logic [N-1:0] pp, input logic [N-1:0] rp,
                           input logic [N-1:0] lp, input logic [N-1:0] lvl);
      exp_q.push_back({32'(cyc + off), pp, rp, lp, lvl});
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic check_reset_zero(input string name);
      check(name, 32'({pressed, press_pulse, release_pulse, long_press}), 32'd0);
   endtask

   // Scoreboard monitor: any pulse on any channel is an output event.
   initial begin
      logic [EW-1:0] act, exp_v;
      forever begin
         @(negedge input_clk);
         if (mon_en && (press_pulse | release_pulse | long_press) != '0) begin
            act = {32'(cyc), press_pulse, release_pulse, long_press, pressed};
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fails++;
               $display("FAIL unexpected_event: got cyc=%0d pp=%b rp=%b lp=%b lvl=%b, expected no event",
                        act[EW-1:12], act[11:9], act[8:6], act[5:3], act[2:0]);
            end else begin
               exp_v = exp_q.pop_front();
               if (act !== exp_v) begin
                  n_fails++;
                  $display("FAIL event: got cyc=%0d pp=%b rp=%b lp=%b lvl=%b, expected cyc=%0d pp=%b rp=%b lp=%b lvl=%b",
                           act[EW-1:12], act[11:9], act[8:6], act[5:3], act[2:0],
                           exp_v[EW-1:12], exp_v[11:9], exp_v[8:6], exp_v[5:3], exp_v[2:0]);
               end
            end
         end
      end
   end

   // Directed stimulus
   initial begin
      n_checks  = 0;
      n_fails   = 0;
      mon_en    = 1'b0;
      reset     = 1'b1;
      buttons_n = 3'b000;

      // Reset for 5 edges with all buttons held, outputs must stay 0.
      for (int k = 0; k < 5; k++) begin
         wait_cyc(1);
         mon_en = 1'b1;
         check_reset_zero("reset_hold_zero");
      end
      reset = 1'b0;
      push_exp(6,  3'b111, 3'b000, 3'b000, 3'b111);
      push_exp(16, 3'b000, 3'b000, 3'b111, 3'b111);
      wait_cyc(20);
      buttons_n = 3'b111;
      push_exp(6,  3'b000, 3'b111, 3'b000, 3'b000);
      wait_cyc(10);
      check("all_released_level", 32'(pressed), 32'b000);

      // Clean press on channel 0, then long press once over 100+ cycles.
      buttons_n = 3'b110;
      push_exp(6,  3'b001, 3'b000, 3'b000, 3'b001);
      push_exp(16, 3'b000, 3'b000, 3'b001, 3'b001);
      wait_cyc(8);
      check("clean_press_level", 32'(pressed), 32'b001);
      wait_cyc(112);

      // Release glitch of two cycles: no release, level stays pressed.
      buttons_n = 3'b111;
      wait_cyc(2);
      buttons_n = 3'b110;
      wait_cyc(10);
      check("glitch_level_held", 32'(pressed), 32'b001);
      buttons_n = 3'b111;
      push_exp(6,  3'b000, 3'b001, 3'b000, 3'b000);
      wait_cyc(10);
      check("real_release_level", 32'(pressed), 32'b000);

      // Bounce: low 3, high 1, then low; press counted from the last fall.
      buttons_n = 3'b110;
      wait_cyc(3);
      buttons_n = 3'b111;
      wait_cyc(1);
      buttons_n = 3'b110;
      push_exp(6,  3'b001, 3'b000, 3'b000, 3'b001);
      wait_cyc(8);
      buttons_n = 3'b111;
      push_exp(6,  3'b000, 3'b001, 3'b000, 3'b000);
      wait_cyc(12);

      // Reset in the middle of PRESS_WAIT on channel 1.
      buttons_n = 3'b101;
      wait_cyc(3);
      reset = 1'b1;
      for (int k = 0; k < 3; k++) begin
         wait_cyc(1);
         check_reset_zero("midop_reset_zero");
      end
      reset = 1'b0;
      push_exp(6,  3'b010, 3'b000, 3'b000, 3'b010);
      push_exp(16, 3'b000, 3'b000, 3'b010, 3'b010);
      wait_cyc(20);
      buttons_n = 3'b111;
      push_exp(6,  3'b000, 3'b010, 3'b000, 3'b000);
      wait_cyc(12);

      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
